// File: rtl/bus_dma_master.sv
// rtl/bus_dma_master.sv - word-copy bus initiator sharing the CPU we/addr/wd/rd bus
// Reads one source word, writes it to the destination, repeats for len words.
module bus_dma_master #(
   parameter int LEN_W        = 16,
   parameter int READ_LATENCY = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [31:0]      i_src_addr,
   input  logic [31:0]      i_dst_addr,
   input  logic [LEN_W-1:0] i_len,
   input  logic             i_bus_gnt,
   input  logic [31:0]      i_rd,
   output logic             o_bus_req,
   output logic             o_we,
   output logic [31:0]      o_addr,
   output logic [31:0]      o_wd,
   output logic             o_busy,
   output logic             o_done
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_RD   = 3'd2;
   localparam logic [2:0] S_WR   = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam int LAT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY);

   logic [2:0]       r_state;
   logic [31:0]      r_src_ptr;
   logic [31:0]      r_dst_ptr;
   logic [LEN_W-1:0] r_remaining;
   logic [31:0]      r_data;
   logic [LAT_W-1:0] r_lat;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_src_ptr   <= '0;
         r_dst_ptr   <= '0;
         r_remaining <= '0;
         r_data      <= '0;
         r_lat       <= '0;
      end else if (r_state != S_IDLE && i_abort) begin
         // abort returns to IDLE from anywhere; a WR already on the bus has completed
         r_state <= S_IDLE;
         r_lat   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start && !i_abort) begin
                  if (i_len != '0) begin
                     r_src_ptr   <= {i_src_addr[31:2], 2'b00};
                     r_dst_ptr   <= {i_dst_addr[31:2], 2'b00};
                     r_remaining <= i_len;
                     r_state     <= S_REQ;
                  end else begin
                     r_state <= S_DONE;
                  end
               end
            end
            S_REQ: begin
               if (i_bus_gnt) begin
                  r_state <= S_RD;
                  r_lat   <= '0;
               end
            end
            S_RD: begin
               if (r_lat == LAT_LAST) begin
                  r_data  <= i_rd;
                  r_lat   <= '0;
                  r_state <= S_WR;
               end else begin
                  r_lat <= r_lat + LAT_W'(1);
               end
            end
            S_WR: begin
               r_src_ptr   <= r_src_ptr + 32'd4;
               r_dst_ptr   <= r_dst_ptr + 32'd4;
               r_remaining <= r_remaining - LEN_W'(1);
               r_state     <= (r_remaining == LEN_W'(1)) ? S_DONE : S_RD;
            end
            S_DONE: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Outside RD/WR the bus lines sit at the decoder's idle values (all zero)
   assign o_bus_req = (r_state == S_REQ) || (r_state == S_RD) || (r_state == S_WR);
   assign o_we      = (r_state == S_WR);
   assign o_addr    = (r_state == S_RD) ? r_src_ptr :
                      (r_state == S_WR) ? r_dst_ptr : 32'd0;
   assign o_wd      = (r_state == S_WR) ? r_data : 32'd0;
   assign o_busy    = (r_state != S_IDLE);
   assign o_done    = (r_state == S_DONE);

endmodule

// File: tb/tb_bus_dma_master.sv
// tb/tb_bus_dma_master.sv - bench for bus_dma_master
// Two instances (read latency 1 and 0); per-cycle outputs compared to a trace built from the transfer rules.
module tb_bus_dma_master;

   typedef logic [67:0] vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start [2];
   logic        abrt  [2];
   logic        gnt   [2];
   logic [31:0] src   [2];
   logic [31:0] dst   [2];
   logic [15:0] len   [2];
   logic [31:0] rdv   [2];
   logic        req   [2];
   logic        we    [2];
   logic        busy  [2];
   logic        done  [2];
   logic [31:0] addr  [2];
   logic [31:0] wd    [2];
   logic [31:0] rd_q;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   bus_dma_master #(.LEN_W(16), .READ_LATENCY(1)) u_dma_l1 (
      .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_abort(abrt[0]),
      .i_src_addr(src[0]), .i_dst_addr(dst[0]), .i_len(len[0]),
      .i_bus_gnt(gnt[0]), .i_rd(rdv[0]),
      .o_bus_req(req[0]), .o_we(we[0]), .o_addr(addr[0]), .o_wd(wd[0]),
      .o_busy(busy[0]), .o_done(done[0]));

   bus_dma_master #(.LEN_W(16), .READ_LATENCY(0)) u_dma_l0 (
      .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_abort(abrt[1]),
      .i_src_addr(src[1]), .i_dst_addr(dst[1]), .i_len(len[1]),
      .i_bus_gnt(gnt[1]), .i_rd(rdv[1]),
      .o_bus_req(req[1]), .o_we(we[1]), .o_addr(addr[1]), .o_wd(wd[1]),
      .o_busy(busy[1]), .o_done(done[1]));

   function automatic logic [31:0] src_word(input logic [31:0] a);
      if (a >= 32'h10000 && a < 32'h1000C)
         return 32'h11111111 * ((a - 32'h10000) / 32'd4 + 32'd1);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5AC3C3;
   endfunction

   always_ff @(posedge clk) rd_q <= src_word(addr[0]);
   assign rdv[0] = rd_q;
   assign rdv[1] = src_word(addr[1]);

   function automatic vec_t pk(input logic b, input logic r, input logic w, input logic dn,
                               input logic [31:0] a, input logic [31:0] dat);
      return {b, r, w, dn, a, dat};
   endfunction

   task automatic check(input string tag, input vec_t got, input vec_t exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got busy,req,we,done=%b addr=%h wd=%h, expected busy,req,we,done=%b addr=%h wd=%h",
                  tag, got[67:64], got[63:32], got[31:0], exp[67:64], exp[63:32], exp[31:0]);
      end
   endtask

   function automatic vec_t obs(input int u);
      return pk(busy[u], req[u], we[u], done[u], addr[u], wd[u]);
   endfunction

   // ab: trace cycle (1-based) in which abort (or rst) is held; 0 = none
   task automatic run(input string name, input int u, input logic [31:0] s, input logic [31:0] d,
                      input int n, input int gd, input int ab, input bit use_rst, input bit restart);
      vec_t tr[$];
      int L = (u == 0) ? 1 : 0;
      logic [31:0] sa = s & ~32'd3;
      logic [31:0] da = d & ~32'd3;
      if (n == 0) begin
         tr.push_back(pk(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0));
      end else begin
         for (int i = 0; i <= gd; i++) tr.push_back(pk(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0));
         for (int w = 0; w < n; w++) begin
            for (int j = 0; j <= L; j++)
               tr.push_back(pk(1'b1, 1'b1, 1'b0, 1'b0, sa + 32'(4 * w), 32'd0));
            tr.push_back(pk(1'b1, 1'b1, 1'b1, 1'b0, da + 32'(4 * w), src_word(sa + 32'(4 * w))));
         end
         tr.push_back(pk(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0));
      end
      if (ab >= 1 && ab < tr.size())
         while (tr.size() > ab) void'(tr.pop_back());
      tr.push_back('0);
      tr.push_back('0);

      @(negedge clk);
      src[u]   = s;
      dst[u]   = d;
      len[u]   = 16'(n);
      start[u] = 1'b1;
      gnt[u]   = 1'b0;
      @(posedge clk);
      for (int k = 1; k <= tr.size(); k++) begin
         @(negedge clk);
         check($sformatf("u%0d/%s c%0d", u, name, k), obs(u), tr[k-1]);
         start[u] = restart && (k == 2);
         if (restart && k == 2) begin
            src[u] = $urandom;
            dst[u] = $urandom;
            len[u] = 16'($urandom_range(1, 9));
         end
         gnt[u]  = (k > gd);
         abrt[u] = !use_rst && (k == ab);
         rst     = use_rst && (k == ab);
      end
      @(negedge clk);
      gnt[u]   = 1'b0;
      abrt[u]  = 1'b0;
      start[u] = 1'b0;
      rst      = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      for (int u = 0; u < 2; u++) begin
         start[u] = 1'b1; abrt[u] = 1'b0; gnt[u] = 1'b1;
         src[u] = 32'h10000; dst[u] = 32'h20000; len[u] = 16'd3;
      end
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         @(negedge clk);
         for (int u = 0; u < 2; u++) check($sformatf("u%0d/reset%0d", u, i), obs(u), '0);
      end
      rst = 1'b0;
      for (int u = 0; u < 2; u++) begin start[u] = 1'b0; gnt[u] = 1'b0; end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         for (int u = 0; u < 2; u++) check($sformatf("u%0d/post_reset%0d", u, i), obs(u), '0);
      end

      // abort and start together in IDLE: stays idle
      start[0] = 1'b1; abrt[0] = 1'b1; len[0] = 16'd3;
      @(negedge clk);
      start[0] = 1'b0; abrt[0] = 1'b0;
      check("u0/abort_start", obs(0), '0);
      @(negedge clk);
      check("u0/abort_start2", obs(0), '0);

      run("copy3",   0, 32'h10000,    32'h20000, 3, 0, 0, 1'b0, 1'b0);
      run("zero",    0, 32'h10000,    32'h20000, 0, 0, 0, 1'b0, 1'b0);
      run("gnt5",    0, 32'h10000,    32'h20000, 3, 5, 0, 1'b0, 1'b0);
      run("abort",   0, 32'h10003,    32'h30001, 4, 0, 5, 1'b0, 1'b0);
      run("wrap",    1, 32'hFFFFFFFC, 32'h40000, 2, 0, 0, 1'b0, 1'b1);
      run("rst_mid", 1, 32'h50000,    32'h60000, 3, 1, 4, 1'b1, 1'b0);
      run("zero_l0", 1, 32'h0,        32'h0,     0, 0, 0, 1'b0, 1'b0);

      for (int r = 0; r < 16; r++) begin
         int ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0;
         run($sformatf("rnd%0d", r), r % 2, $urandom, $urandom, int'($urandom_range(1, 6)),
             int'($urandom_range(0, 3)), ab, 1'b0, ($urandom_range(0, 1) == 1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
